// File: rtl/lp_tmem_pm.sv
`default_nettype none
// ============================================================================
// lp_tmem_pm : dual-port multi-bank FFT data memory with autonomous
//              light-sleep / deep-sleep / shutdown power-state control.
// Revision   : 1.0
// ============================================================================
module lp_tmem_pm #(
  parameter int NUM_BANK = 32,
  parameter int WORD_W   = 24,
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int LS_IDLE  = 16,
  parameter int DS_IDLE  = 256,
  parameter int WAKE_LS  = 1,
  parameter int WAKE_DS  = 4,
  parameter int WAKE_SD  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         p1_req,
  input  logic                         p1_we,
  input  logic [ADDR_W-1:0]            p1_addr,
  input  logic [NUM_BANK*WORD_W-1:0]   p1_wdata,
  output logic                         p1_ready,
  output logic                         p1_rvalid,
  output logic [NUM_BANK*WORD_W-1:0]   p1_rdata,
  input  logic                         p2_req,
  input  logic                         p2_we,
  input  logic [ADDR_W-1:0]            p2_addr,
  input  logic [NUM_BANK*WORD_W-1:0]   p2_wdata,
  output logic                         p2_ready,
  output logic                         p2_rvalid,
  output logic [NUM_BANK*WORD_W-1:0]   p2_rdata,
  input  logic                         shutdown_req,
  output logic [2:0]                   pwr_state
);

  localparam int DW    = NUM_BANK * WORD_W;
  localparam int IC_W  = $clog2(DS_IDLE + 1);
  localparam int WMAX  = (WAKE_SD > WAKE_DS) ? ((WAKE_SD > WAKE_LS) ? WAKE_SD : WAKE_LS)
                                             : ((WAKE_DS > WAKE_LS) ? WAKE_DS : WAKE_LS);
  localparam int WK_W  = $clog2(WMAX + 1);
  localparam int IX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IC_W-1:0]   LS_TH   = IC_W'(LS_IDLE - 1);
  localparam logic [IC_W-1:0]   DS_TH   = IC_W'(DS_IDLE - 1);
  localparam logic [IC_W-1:0]   IC_MAX  = IC_W'(DS_IDLE);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [WK_W-1:0]   WK_ONE  = WK_W'(1);

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_LS     = 3'd1,
    ST_DS     = 3'd2,
    ST_SD     = 3'd3,
    ST_WAKE   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [IC_W-1:0] idle_cnt, idle_nxt;
  logic [WK_W-1:0] wake_cnt, wake_nxt;
  logic            any_req;
  logic            p1_acc, p2_acc, p1_in, p2_in;
  logic [DW-1:0]   mem [DEPTH];

  assign any_req   = p1_req | p2_req;
  assign p1_ready  = (state == ST_ACTIVE) & ~shutdown_req;
  assign p2_ready  = (state == ST_ACTIVE) & ~shutdown_req;
  assign p1_acc    = p1_req & p1_ready;
  assign p2_acc    = p2_req & p2_ready;
  assign p1_in     = {1'b0, p1_addr} < DEPTH_L;
  assign p2_in     = {1'b0, p2_addr} < DEPTH_L;
  assign pwr_state = state;

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    wake_nxt  = wake_cnt;
    if (any_req || shutdown_req) begin
      idle_nxt = '0;
    end else if ((state inside {ST_ACTIVE, ST_LS, ST_DS}) && idle_cnt != IC_MAX) begin
      idle_nxt = idle_cnt + 1'b1;
    end
    if (shutdown_req) begin
      state_nxt = ST_SD;
    end else begin
      case (state)
        ST_ACTIVE: if (!any_req && idle_cnt == LS_TH) state_nxt = ST_LS;
        ST_LS: begin
          if (any_req) begin
            state_nxt = ST_WAKE;
            wake_nxt  = WK_W'(WAKE_LS);
          end else if (idle_cnt == DS_TH) begin
            state_nxt = ST_DS;
          end
        end
        ST_DS: if (any_req) begin
          state_nxt = ST_WAKE;
          wake_nxt  = WK_W'(WAKE_DS);
        end
        ST_SD: if (any_req) begin
          state_nxt = ST_WAKE;
          wake_nxt  = WK_W'(WAKE_SD);
        end
        ST_WAKE: begin
          // Wake completes even if the requester has since withdrawn.
          wake_nxt = wake_cnt - 1'b1;
          if (wake_cnt == WK_ONE) begin
            state_nxt = ST_ACTIVE;
            idle_nxt  = '0;
          end
        end
        default: state_nxt = ST_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ACTIVE;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      wake_cnt <= wake_nxt;
    end
  end

  // Port 1 write is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (shutdown_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (p2_acc && p2_we && p2_in) mem[p2_addr[IX_W-1:0]] <= p2_wdata;
      if (p1_acc && p1_we && p1_in) mem[p1_addr[IX_W-1:0]] <= p1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_rvalid <= 1'b0;
      p1_rdata  <= '0;
    end else if (p1_acc && !p1_we) begin
      p1_rvalid <= 1'b1;
      p1_rdata  <= p1_in ? mem[p1_addr[IX_W-1:0]] : '0;
    end else begin
      p1_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_rvalid <= 1'b0;
      p2_rdata  <= '0;
    end else if (p2_acc && !p2_we) begin
      p2_rvalid <= 1'b1;
      p2_rdata  <= p2_in ? mem[p2_addr[IX_W-1:0]] : '0;
    end else begin
      p2_rvalid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lp_tmem_pm.sv
`default_nettype none
// ============================================================================
// tb_lp_tmem_pm : randomized, self-checking bench for lp_tmem_pm.
// Revision      : 1.0
// ============================================================================
module tb_lp_tmem_pm;

  localparam int NB = 32, WW = 24, DEPTH = 64, AW = 7, DW = NB * WW;
  localparam int LS_IDLE = 16, DS_IDLE = 256, WAKE_LS = 1, WAKE_DS = 4, WAKE_SD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p1_req = 0, p1_we = 0, p2_req = 0, p2_we = 0, shutdown_req = 0;
  logic [AW-1:0] p1_addr = '0, p2_addr = '0;
  logic [DW-1:0] p1_wdata = '0, p2_wdata = '0;
  logic          p1_ready, p1_rvalid, p2_ready, p2_rvalid;
  logic [DW-1:0] p1_rdata, p2_rdata;
  logic [2:0]    pwr_state;

  logic [DW-1:0] ref_mem [DEPTH];
  int n_chk = 0, n_pass = 0;

  lp_tmem_pm #(
    .NUM_BANK(NB), .WORD_W(WW), .DEPTH(DEPTH), .ADDR_W(AW),
    .LS_IDLE(LS_IDLE), .DS_IDLE(DS_IDLE),
    .WAKE_LS(WAKE_LS), .WAKE_DS(WAKE_DS), .WAKE_SD(WAKE_SD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
    .p2_ready(p2_ready), .p2_rvalid(p2_rvalid), .p2_rdata(p2_rdata),
    .shutdown_req(shutdown_req), .pwr_state(pwr_state)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fill(input logic [WW-1:0] v);
    return {NB{v}};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < NB; i++) w[i*WW +: WW] = WW'($urandom);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    p1_req = 0; p2_req = 0; p1_we = 0; p2_we = 0;
  endtask

  task automatic test_reset();
    idle_ports();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #3;
    n_chk++; if (pwr_state !== 3'd0) $display("FAIL reset_pwr got=%0d want=0", pwr_state); else n_pass++;
    n_chk++; if (p1_rvalid !== 1'b0 || p2_rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b%b want=00", p1_rvalid, p2_rvalid); else n_pass++;
    n_chk++; if (p1_rdata !== '0 || p2_rdata !== '0) $display("FAIL reset_rdata got nonzero want=0"); else n_pass++;
    n_chk++; if (p1_ready !== 1'b1 || p2_ready !== 1'b1) $display("FAIL reset_ready got=%b%b want=11", p1_ready, p2_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_write_read();
    p1_req = 1; p1_we = 1; p1_addr = 5; p1_wdata = fill(24'hABCDEF);
    ref_mem[5] = fill(24'hABCDEF);
    #1;
    n_chk++; if (p1_ready !== 1'b1) $display("FAIL wr_ready got=%b want=1", p1_ready); else n_pass++;
    tick();
    p1_req = 0; p2_req = 1; p2_we = 0; p2_addr = 5;
    tick();
    p2_req = 0;
    n_chk++; if (p2_rvalid !== 1'b1) $display("FAIL rd_rvalid got=%b want=1", p2_rvalid); else n_pass++;
    n_chk++; if (p2_rdata !== ref_mem[5]) $display("FAIL rd_data got=%h want=%h", p2_rdata, ref_mem[5]); else n_pass++;
    tick();
    n_chk++; if (p2_rvalid !== 1'b0) $display("FAIL rd_pulse got=%b want=0", p2_rvalid); else n_pass++;
    n_chk++; if (p2_rdata !== ref_mem[5]) $display("FAIL rd_hold got=%h want=%h", p2_rdata, ref_mem[5]); else n_pass++;
  endtask

  task automatic test_collision();
    p1_req = 1; p1_we = 1; p1_addr = 9; p1_wdata = fill(24'h111111);
    p2_req = 1; p2_we = 1; p2_addr = 9; p2_wdata = fill(24'h222222);
    ref_mem[9] = fill(24'h111111);
    tick();
    p1_req = 1; p1_we = 1; p1_addr = 9; p1_wdata = fill(24'h333333);
    p2_req = 1; p2_we = 0; p2_addr = 9;
    tick();
    idle_ports();
    n_chk++; if (p2_rdata !== fill(24'h111111) || p2_rvalid !== 1'b1) $display("FAIL wr_rd_old got=%h want=%h", p2_rdata, fill(24'h111111)); else n_pass++;
    ref_mem[9] = fill(24'h333333);
    p1_req = 1; p1_we = 0; p1_addr = 9;
    tick();
    p1_req = 0;
    n_chk++; if (p1_rdata !== ref_mem[9]) $display("FAIL ww_new got=%h want=%h", p1_rdata, ref_mem[9]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d1, d2, e1d, e2d;
    int a1, a2;
    logic r1, r2, w1, w2, e1v, e2v;
    for (int a = 0; a < DEPTH; a += 2) begin
      p1_req = 1; p1_we = 1; p1_addr = AW'(a);     p1_wdata = rand_word(); ref_mem[a]   = p1_wdata;
      p2_req = 1; p2_we = 1; p2_addr = AW'(a + 1); p2_wdata = rand_word(); ref_mem[a+1] = p2_wdata;
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      r1 = ($urandom_range(0, 3) != 0) || (i % 8 == 0);
      r2 = ($urandom_range(0, 3) != 0);
      w1 = 1'($urandom); w2 = 1'($urandom);
      a1 = $urandom_range(0, 79); a2 = $urandom_range(0, 79);
      d1 = rand_word(); d2 = rand_word();
      p1_req = r1; p1_we = w1; p1_addr = AW'(a1); p1_wdata = d1;
      p2_req = r2; p2_we = w2; p2_addr = AW'(a2); p2_wdata = d2;
      e1v = r1 && !w1; e1d = (a1 < DEPTH) ? ref_mem[a1] : '0;
      e2v = r2 && !w2; e2d = (a2 < DEPTH) ? ref_mem[a2] : '0;
      if (r2 && w2 && a2 < DEPTH) ref_mem[a2] = d2;
      if (r1 && w1 && a1 < DEPTH) ref_mem[a1] = d1;
      #1;
      n_chk++; if (p1_ready !== 1'b1 || p2_ready !== 1'b1) $display("FAIL b2b_ready i=%0d got=%b%b want=11", i, p1_ready, p2_ready); else n_pass++;
      tick();
      n_chk++; if (p1_rvalid !== e1v || p2_rvalid !== e2v) $display("FAIL b2b_rvalid i=%0d got=%b%b want=%b%b", i, p1_rvalid, p2_rvalid, e1v, e2v); else n_pass++;
      if (e1v) begin
        n_chk++; if (p1_rdata !== e1d) $display("FAIL b2b_p1_data i=%0d addr=%0d got=%h want=%h", i, a1, p1_rdata, e1d); else n_pass++;
      end
      if (e2v) begin
        n_chk++; if (p2_rdata !== e2d) $display("FAIL b2b_p2_data i=%0d addr=%0d got=%h want=%h", i, a2, p2_rdata, e2d); else n_pass++;
      end
    end
    idle_ports();
  endtask

  task automatic test_sleep_ds_wake();
    int exp_st;
    p1_req = 1; p1_we = 1; p1_addr = 12; p1_wdata = rand_word(); ref_mem[12] = p1_wdata;
    tick();
    idle_ports();
    for (int n = 1; n <= DS_IDLE; n++) begin
      tick();
      exp_st = (n >= DS_IDLE) ? 2 : (n >= LS_IDLE) ? 1 : 0;
      n_chk++; if (int'(pwr_state) != exp_st) $display("FAIL sleep_state n=%0d got=%0d want=%0d", n, pwr_state, exp_st); else n_pass++;
    end
    p2_req = 1; p2_we = 0; p2_addr = 12;
    for (int c = 0; c <= WAKE_DS; c++) begin
      #1;
      exp_st = (c == 0) ? 2 : 4;
      n_chk++; if (p2_ready !== 1'b0 || int'(pwr_state) != exp_st) $display("FAIL ds_wake c=%0d ready=%b st=%0d want ready=0 st=%0d", c, p2_ready, pwr_state, exp_st); else n_pass++;
      tick();
    end
    #1;
    n_chk++; if (p2_ready !== 1'b1 || pwr_state !== 3'd0) $display("FAIL ds_accept ready=%b st=%0d want ready=1 st=0", p2_ready, pwr_state); else n_pass++;
    tick();
    p2_req = 0;
    n_chk++; if (p2_rvalid !== 1'b1 || p2_rdata !== ref_mem[12]) $display("FAIL ds_data got=%h want=%h", p2_rdata, ref_mem[12]); else n_pass++;
  endtask

  task automatic test_ls_wake();
    repeat (LS_IDLE) tick();
    n_chk++; if (pwr_state !== 3'd1) $display("FAIL ls_entry got=%0d want=1", pwr_state); else n_pass++;
    p1_req = 1; p1_we = 0; p1_addr = 12;
    for (int c = 0; c <= WAKE_LS; c++) begin
      #1;
      n_chk++; if (p1_ready !== 1'b0) $display("FAIL ls_wait c=%0d got=%b want=0", c, p1_ready); else n_pass++;
      tick();
    end
    #1;
    n_chk++; if (p1_ready !== 1'b1) $display("FAIL ls_accept got=%b want=1", p1_ready); else n_pass++;
    tick();
    p1_req = 0;
    n_chk++; if (p1_rvalid !== 1'b1 || p1_rdata !== ref_mem[12]) $display("FAIL ls_data got=%h want=%h", p1_rdata, ref_mem[12]); else n_pass++;
  endtask

  task automatic test_shutdown();
    p1_req = 1; p1_we = 1; p1_addr = 3; p1_wdata = fill(24'h00FF00);
    tick();
    p1_we = 0;
    tick();
    p1_req = 0; shutdown_req = 1;
    #1;
    n_chk++; if (p1_ready !== 1'b0) $display("FAIL sd_ready got=%b want=0", p1_ready); else n_pass++;
    n_chk++; if (p1_rvalid !== 1'b1 || p1_rdata !== fill(24'h00FF00)) $display("FAIL sd_prior_read got=%h want=%h", p1_rdata, fill(24'h00FF00)); else n_pass++;
    tick();
    for (int c = 0; c < 2; c++) begin
      p2_req = 1; p2_we = 0; p2_addr = 3;
      #1;
      n_chk++; if (pwr_state !== 3'd3 || p2_ready !== 1'b0) $display("FAIL sd_hold c=%0d st=%0d ready=%b want st=3 ready=0", c, pwr_state, p2_ready); else n_pass++;
      tick();
    end
    shutdown_req = 0; idle_ports();
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    tick();
    n_chk++; if (pwr_state !== 3'd3 || p2_rvalid !== 1'b0) $display("FAIL sd_stay st=%0d rvalid=%b want st=3 rvalid=0", pwr_state, p2_rvalid); else n_pass++;
    p1_req = 1; p1_we = 0; p1_addr = 3;
    for (int c = 0; c <= WAKE_SD; c++) begin
      #1;
      n_chk++; if (p1_ready !== 1'b0) $display("FAIL sd_wake c=%0d got=%b want=0", c, p1_ready); else n_pass++;
      tick();
    end
    #1;
    n_chk++; if (p1_ready !== 1'b1) $display("FAIL sd_accept got=%b want=1", p1_ready); else n_pass++;
    tick();
    p1_addr = 5;
    n_chk++; if (p1_rvalid !== 1'b1 || p1_rdata !== ref_mem[3]) $display("FAIL sd_clear3 got=%h want=%h", p1_rdata, ref_mem[3]); else n_pass++;
    tick();
    p1_req = 0;
    n_chk++; if (p1_rdata !== ref_mem[5]) $display("FAIL sd_clear5 got=%h want=%h", p1_rdata, ref_mem[5]); else n_pass++;
  endtask

  task automatic test_oob_reset();
    p1_req = 1; p1_we = 1; p1_addr = 20; p1_wdata = rand_word(); ref_mem[20] = p1_wdata;
    tick();
    p1_we = 0;
    tick();
    n_chk++; if (p1_rdata !== ref_mem[20]) $display("FAIL pre_oob got=%h want=%h", p1_rdata, ref_mem[20]); else n_pass++;
    p1_addr = 70;
    tick();
    n_chk++; if (p1_rvalid !== 1'b1 || p1_rdata !== '0) $display("FAIL oob_read rvalid=%b data=%h want rvalid=1 data=0", p1_rvalid, p1_rdata); else n_pass++;
    p1_addr = 20;
    tick();
    #2;
    rst_n = 0;
    #1;
    n_chk++; if (p1_rvalid !== 1'b0 || p1_rdata !== '0 || pwr_state !== 3'd0) $display("FAIL rst_mid_read rvalid=%b st=%0d want rvalid=0 st=0", p1_rvalid, pwr_state); else n_pass++;
    idle_ports();
    @(negedge clk);
    rst_n = 1;
    repeat (LS_IDLE) tick();
    n_chk++; if (pwr_state !== 3'd1) $display("FAIL post_rst_ls got=%0d want=1", pwr_state); else n_pass++;
    #2;
    rst_n = 0;
    #1;
    n_chk++; if (pwr_state !== 3'd0) $display("FAIL rst_in_ls got=%0d want=0", pwr_state); else n_pass++;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_back_to_back();
    test_sleep_ds_wake();
    test_ls_wake();
    test_shutdown();
    test_oob_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
